spi_master_ctrl: RTL

- Single-clock SPI master that drives the SPI_Wrapper slave (RAM-backed) from a parallel command interface.
- Converts one {op, byte} command into a complete SS_n/MOSI frame: write address, write data, read address or read data.
- For read-data frames, it captures the byte returned on MISO and presents it to the host.
- Sits directly upstream of SPI_Wrapper and shares its clk; no separate SCLK.

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_shift_reg.sv | 18 +
 rtl/spi_master_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: opcodes, slave state constants and master FSM encoding.
package spi_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // SPI_Wrapper slave states, kept here so both ends share one definition file.
    localparam logic [2:0] SLV_IDLE      = 3'd0;
    localparam logic [2:0] SLV_CHK_CMD   = 3'd1;
    localparam logic [2:0] SLV_WRITE     = 3'd2;
    localparam logic [2:0] SLV_READ_ADD  = 3'd3;
    localparam logic [2:0] SLV_READ_DATA = 3'd4;

    typedef enum logic [2:0] {
        M_IDLE,
        M_SEL,
        M_CMD,
        M_DATA_OUT,
        M_DUMMY,
        M_TURN,
        M_CAPTURE,
        M_GAP
    } mstate_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/spi_shift_reg.sv
// 8-bit MSB-first shift register: parallel load for MOSI, serial-in for MISO capture.
module spi_shift_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       shift_en,
    input  logic       serial_in,
    input  logic [7:0] load_data,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (rst)           q <= 8'h00;
        else if (load)     q <= load_data;
        else if (shift_en) q <= {q[6:0], serial_in};
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master for the SPI_Wrapper slave: turns one {op, byte} command into a full SS_n/MOSI frame.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DUMMY_BITS = 8,
    parameter int TURNAROUND = 1,
    parameter int GAP        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    mstate_e          state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op;
    logic [7:0]       sr_q;
    logic             accept;
    logic             shift_en;

    assign accept = cmd_valid && cmd_ready;

    // The shift register is one step ahead of MOSI: it advances as each data bit is registered out.
    always_comb begin
        shift_en = 1'b0;
        case (state)
            M_CMD:      shift_en = (cnt == '0) && (op != OP_RD_DATA);
            M_DATA_OUT: shift_en = (cnt != '0);
            M_CAPTURE:  shift_en = 1'b1;
            default:    shift_en = 1'b0;
        endcase
    end

    spi_shift_reg u_sr (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift_en  (shift_en),
        .serial_in (MISO),
        .load_data (cmd_data),
        .q         (sr_q)
    );

    // cnt holds the number of bits still to follow the one currently on the wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= M_IDLE;
            cnt       <= '0;
            op        <= 2'b00;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= 8'h00;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                M_IDLE: if (accept) begin
                    state     <= M_SEL;
                    op        <= cmd_op;
                    SS_n      <= 1'b0;
                    MOSI      <= 1'b0;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                end
                M_SEL: begin
                    state <= M_CMD;
                    MOSI  <= op[1];
                    cnt   <= CNT_W'(2);
                end
                M_CMD: if (cnt != '0) begin
                    cnt  <= cnt - 1'b1;
                    MOSI <= (cnt == CNT_W'(2)) ? op[1] : op[0];
                end else if (op == OP_RD_DATA) begin
                    state <= M_DUMMY;
                    MOSI  <= 1'b0;
                    cnt   <= CNT_W'(DUMMY_BITS - 1);
                end else begin
                    state <= M_DATA_OUT;
                    MOSI  <= sr_q[7];
                    cnt   <= CNT_W'(7);
                end
                M_DATA_OUT: if (cnt != '0) begin
                    cnt  <= cnt - 1'b1;
                    MOSI <= sr_q[7];
                end else begin
                    state <= M_GAP;
                    SS_n  <= 1'b1;
                    MOSI  <= 1'b0;
                    cnt   <= CNT_W'(GAP - 1);
                end
                M_DUMMY: if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
                    state <= M_TURN;
                    cnt   <= CNT_W'(TURNAROUND - 1);
                end
                M_TURN: if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
                    state <= M_CAPTURE;
                    cnt   <= CNT_W'(7);
                end
                M_CAPTURE: if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
                    state    <= M_GAP;
                    SS_n     <= 1'b1;
                    rd_valid <= 1'b1;
                    rd_data  <= {sr_q[6:0], MISO};
                    cnt      <= CNT_W'(GAP - 1);
                end
                M_GAP: if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
                    state     <= M_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= M_IDLE;
            endcase
        end
    end

endmodule
